// File: rtl/icache_ctrl_if.sv
// rtl/icache_ctrl_if.sv - fetch request and byte-wide refill RAM bundle for icache_ctrl
interface icache_ctrl_if;
  logic        flush;
  logic        instEn;
  logic [31:0] instAddr;
  logic        hit;
  logic [31:0] cacheInst;
  logic        memInstOutEn;
  logic [31:0] memInst;
  logic        ram_rd;
  logic [31:0] ram_a;
  logic [7:0]  ram_din;

  // Cache controller side: takes fetch requests and RAM bytes, answers hits and refills
  modport slave (
    input  flush, instEn, instAddr, ram_din,
    output hit, cacheInst, memInstOutEn, memInst, ram_rd, ram_a
  );

  // Fetch unit / memory side
  modport master (
    output flush, instEn, instAddr, ram_din,
    input  hit, cacheInst, memInstOutEn, memInst, ram_rd, ram_a
  );
endinterface

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped one-word-line instruction cache with byte-serial refill
module icache_ctrl #(
  parameter int INDEX_BITS = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  icache_ctrl_if.slave bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [2:0]            byte_cnt;   // READ step: 0..3 issue bytes, 1..4 capture byte cnt-1
  logic [29:0]           word_addr;  // latched miss word address A[31:2]
  logic [23:0]           fill_buf;   // bytes 0..2 of the word being refilled
  logic [31:0]           mem_inst_q;
  logic [LINES-1:0]      valid;
  logic [31:0]           data_arr [LINES];
  logic [TAG_BITS-1:0]   tag_arr  [LINES];

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  active;
  logic                  hit_c;
  logic                  start_miss;
  logic                  line_write;
  logic                  unused_addr_bits;

  assign req_index  = bus.instAddr[2+INDEX_BITS-1:2];
  assign req_tag    = bus.instAddr[31:2+INDEX_BITS];
  assign fill_index = word_addr[INDEX_BITS-1:0];
  assign fill_tag   = word_addr[29:INDEX_BITS];

  // Instruction fetches are word aligned; the byte offset carries no information here
  assign unused_addr_bits = &{1'b0, bus.instAddr[1:0]};

  // A cycle only does work when the pipeline is ready and not being reset
  assign active = rdy & ~rst;

  assign hit_c = active & (state == IDLE) & bus.instEn & valid[req_index] &
                 (tag_arr[req_index] == req_tag);

  // A flush in IDLE redirects the fetch stream, so the request is not worth refilling
  assign start_miss = active & (state == IDLE) & bus.instEn & ~hit_c & ~bus.flush;

  // The completed word is committed in DONE even when that cycle is flushed
  assign line_write = active & (state == DONE);

  assign bus.hit          = hit_c;
  assign bus.cacheInst    = data_arr[req_index];
  assign bus.memInst      = mem_inst_q;
  assign bus.memInstOutEn = active & (state == DONE) & ~bus.flush;
  assign bus.ram_rd       = active & (state == READ) & ~bus.flush & ~byte_cnt[2];
  assign bus.ram_a        = rst ? 32'd0 : {word_addr, byte_cnt[1:0]};

  // Miss sequencer: latch the request, walk four byte reads, then commit the line
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= 3'd0;
      word_addr  <= 30'd0;
      fill_buf   <= 24'd0;
      mem_inst_q <= 32'd0;
      valid      <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (start_miss) begin
            word_addr <= bus.instAddr[31:2];
            byte_cnt  <= 3'd0;
            state     <= READ;
          end
        end
        READ: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            // RAM answers one cycle after the strobe, so capture trails issue by one step
            case (byte_cnt)
              3'd1:    fill_buf[7:0]   <= bus.ram_din;
              3'd2:    fill_buf[15:8]  <= bus.ram_din;
              3'd3:    fill_buf[23:16] <= bus.ram_din;
              3'd4:    mem_inst_q      <= {bus.ram_din, fill_buf};
              default: ;
            endcase
            if (byte_cnt == 3'd4) begin
              state <= DONE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        DONE: begin
          valid[fill_index] <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage; contents are don't-care until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (line_write) begin
      data_arr[fill_index] <= mem_inst_q;
      tag_arr[fill_index]  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - randomized self-checking bench for icache_ctrl
module tb_icache_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   tests_run = 0;
  int   fails = 0;
  int   cycle_no = 0;
  int   t0 = 0;

  icache_ctrl_if bus();

  icache_ctrl #(.INDEX_BITS(7)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  // Byte-wide RAM: data of the strobed address appears next cycle and is held until the next strobe
  logic [7:0] ram_over [int unsigned];

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (ram_over.exists(a)) return ram_over[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5 ^ {a[4:0], a[7:5]};
  endfunction

  always @(posedge clk) begin
    if (rst) bus.ram_din <= 8'd0;
    else if (bus.ram_rd) bus.ram_din <= ram_byte(bus.ram_a);
  end

  // Log of every RAM strobe, relative to the start of the current request
  int          rd_rel[$];
  logic [31:0] rd_addr[$];

  always @(negedge clk) begin
    if (bus.ram_rd) begin
      rd_rel.push_back(cycle_no - t0);
      rd_addr.push_back(bus.ram_a);
    end
  end

  // Reference cache contents: which word address each slot holds
  bit          mdl_valid [128];
  logic [29:0] mdl_line  [128];
  logic [31:0] mdl_word  [128];
  logic [31:0] mdl_meminst;

  function automatic bit mdl_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[8:2]);
    return mdl_valid[idx] && (mdl_line[idx] == a[31:2]);
  endfunction

  // Expected timeline of one miss
  int          ex_rd_rel[$];
  int          ex_pulse_rel;
  bit          ex_written;
  bit          ex_hit0;
  bit          ex_re_hit;
  logic [31:0] ex_re_inst;
  logic [31:0] ex_word;
  logic [31:0] ex_a;

  // Observations of one miss
  int          ob_pulse_rel;
  int          ob_pulse_cnt;
  logic [31:0] ob_word;
  bit          ob_both;
  logic        ob_hit0;
  logic        ob_rd0;
  logic        ob_re_hit;
  logic [31:0] ob_re_inst;
  logic [31:0] ob_meminst_end;

  // A refill needs six non-stalled cycles after the request: four reads, the last capture, the commit
  task automatic build_expect(input int flush_at, input int stall_at, input int stall_len);
    int act;
    act = 0;
    ex_rd_rel.delete();
    ex_pulse_rel = -1;
    ex_written = 1'b0;
    for (int rel = 1; rel < 14 && act < 6; rel++) begin
      if (rel >= stall_at && rel < stall_at + stall_len) continue;
      if (rel == flush_at && act < 5) break;
      if (act < 4) ex_rd_rel.push_back(rel);
      if (act == 5) begin
        ex_written = 1'b1;
        if (rel != flush_at) ex_pulse_rel = rel;
      end
      act++;
    end
  endtask

  function automatic int sched_errs(input logic [31:0] a);
    int e;
    int n;
    e = (rd_rel.size() != ex_rd_rel.size()) ? 1 : 0;
    n = (rd_rel.size() < ex_rd_rel.size()) ? rd_rel.size() : ex_rd_rel.size();
    for (int i = 0; i < n; i++) begin
      if (rd_rel[i] != ex_rd_rel[i] || rd_addr[i] !== a + 32'(i)) e++;
    end
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_miss(input logic [31:0] addr, input int flush_at, input int stall_at,
                          input int stall_len, input bit noise, input int re_at,
                          input logic [31:0] re_addr);
    int noise_end;
    noise_end = (flush_at >= 0) ? flush_at + 1 : 6;
    rd_rel.delete();
    rd_addr.delete();
    ob_pulse_rel = -1;
    ob_pulse_cnt = 0;
    ob_word = '0;
    ob_both = 1'b0;
    ob_re_hit = 1'b0;
    ob_re_inst = '0;
    t0 = cycle_no;
    for (int rel = 0; rel < 14; rel++) begin
      rdy = !(rel >= stall_at && rel < stall_at + stall_len);
      bus.flush = (rel == flush_at);
      if (rel == 0) begin
        bus.instEn = 1'b1;
        bus.instAddr = addr;
      end else if (rel == re_at) begin
        bus.instEn = 1'b1;
        bus.instAddr = re_addr;
      end else if (noise && rel < noise_end) begin
        bus.instEn = 1'($urandom_range(0, 1));
        bus.instAddr = $urandom;
      end else begin
        bus.instEn = 1'b0;
        bus.instAddr = $urandom;
      end
      @(negedge clk);
      if (rel == 0) begin
        ob_hit0 = bus.hit;
        ob_rd0 = bus.ram_rd;
      end
      if (rel == re_at) begin
        ob_re_hit = bus.hit;
        ob_re_inst = bus.cacheInst;
      end
      if (bus.memInstOutEn === 1'b1) begin
        ob_pulse_cnt++;
        if (ob_pulse_rel < 0) begin
          ob_pulse_rel = rel;
          ob_word = bus.memInst;
        end
      end
      if (bus.memInstOutEn === 1'b1 && bus.hit === 1'b1) ob_both = 1'b1;
      next_cycle();
    end
    bus.instEn = 1'b0;
    bus.flush = 1'b0;
    rdy = 1'b1;
  endtask

  task automatic do_miss(input logic [31:0] addr, input int flush_at, input int stall_at,
                         input int stall_len, input bit noise, input int re_at,
                         input logic [31:0] re_addr);
    int idx;
    idx = int'(addr[8:2]);
    ex_a = {addr[31:2], 2'b00};
    ex_hit0 = mdl_hit(addr);
    ex_word = {ram_byte(ex_a + 32'd3), ram_byte(ex_a + 32'd2), ram_byte(ex_a + 32'd1), ram_byte(ex_a)};
    build_expect(flush_at, stall_at, stall_len);
    run_miss(addr, flush_at, stall_at, stall_len, noise, re_at, re_addr);
    if (ex_written) begin
      mdl_valid[idx] = 1'b1;
      mdl_line[idx] = addr[31:2];
      mdl_word[idx] = ex_word;
      mdl_meminst = ex_word;
    end
    ex_re_hit = mdl_hit(re_addr);
    ex_re_inst = mdl_word[int'(re_addr[8:2])];
    ob_meminst_end = bus.memInst;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    bus.flush = 1'b0;
    bus.instEn = 1'b1;
    bus.instAddr = 32'h0000_0104;
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests_run++; if (bus.hit !== 1'b0) begin fails++; $display("FAIL reset_hit: got %b want 0", bus.hit); end
    tests_run++; if (bus.memInstOutEn !== 1'b0) begin fails++; $display("FAIL reset_outen: got %b want 0", bus.memInstOutEn); end
    tests_run++; if (bus.ram_rd !== 1'b0) begin fails++; $display("FAIL reset_ram_rd: got %b want 0", bus.ram_rd); end
    tests_run++; if (bus.ram_a !== 32'd0) begin fails++; $display("FAIL reset_ram_a: got %h want 0", bus.ram_a); end
    tests_run++; if (bus.memInst !== 32'd0) begin fails++; $display("FAIL reset_meminst: got %h want 0", bus.memInst); end
    for (int i = 0; i < 128; i++) mdl_valid[i] = 1'b0;
    mdl_meminst = 32'd0;
    // Start a miss, then reset it two cycles into READ
    next_cycle();
    rst = 1'b0;
    next_cycle();
    bus.instEn = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.ram_rd !== 1'b0) begin fails++; $display("FAIL reset_midread_rd: got %b want 0", bus.ram_rd); end
    next_cycle();
    rst = 1'b0;
    begin
      int pulses;
      int reads;
      pulses = 0;
      reads = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.memInstOutEn === 1'b1) pulses++;
        if (bus.ram_rd === 1'b1) reads++;
        next_cycle();
      end
      tests_run++; if (pulses != 0 || reads != 0) begin fails++; $display("FAIL reset_abort: got %0d pulses %0d reads want 0 0", pulses, reads); end
    end
    tests_run++; if (bus.memInst !== 32'd0) begin fails++; $display("FAIL reset_abort_meminst: got %h want 0", bus.memInst); end
  endtask

  task automatic test_cold_miss();
    do_miss(32'h0000_0104, -1, -1, 0, 1'b1, -1, 32'd0);
    tests_run++; if (ob_hit0 !== 1'b0 || ob_rd0 !== 1'b0) begin fails++; $display("FAIL cold_first_cycle: got hit=%b rd=%b want 0 0", ob_hit0, ob_rd0); end
    tests_run++; if (sched_errs(32'h0000_0104) != 0) begin fails++; $display("FAIL cold_ram_seq: got %0d reads, first at T+%0d, want 0x104..0x107 at T+1..T+4", rd_rel.size(), (rd_rel.size() > 0) ? rd_rel[0] : -1); end
    tests_run++; if (ob_pulse_rel != 6 || ob_pulse_cnt != 1) begin fails++; $display("FAIL cold_pulse: got T+%0d x%0d want T+6 x1", ob_pulse_rel, ob_pulse_cnt); end
    tests_run++; if (ob_word !== 32'h0010_0513) begin fails++; $display("FAIL cold_word: got %h want 00100513", ob_word); end
    tests_run++; if (ob_meminst_end !== 32'h0010_0513) begin fails++; $display("FAIL cold_meminst_hold: got %h want 00100513", ob_meminst_end); end
  endtask

  task automatic test_warm_hit();
    bus.instEn = 1'b1;
    bus.instAddr = 32'h0000_0104;
    @(negedge clk);
    tests_run++; if (bus.hit !== 1'b1) begin fails++; $display("FAIL warm_hit: got %b want 1", bus.hit); end
    tests_run++; if (bus.cacheInst !== 32'h0010_0513) begin fails++; $display("FAIL warm_data: got %h want 00100513", bus.cacheInst); end
    tests_run++; if (bus.ram_rd !== 1'b0 || bus.memInstOutEn !== 1'b0) begin fails++; $display("FAIL warm_quiet: got rd=%b outen=%b want 0 0", bus.ram_rd, bus.memInstOutEn); end
    next_cycle();
    bus.instEn = 1'b0;
    // Re-request right as the refill returns to IDLE
    do_miss(32'h0000_0A10, -1, -1, 0, 1'b0, 7, 32'h0000_0A10);
    tests_run++; if (ob_pulse_rel != 6) begin fails++; $display("FAIL warm_t7_pulse: got T+%0d want T+6", ob_pulse_rel); end
    tests_run++; if (ob_re_hit !== 1'b1 || ob_re_inst !== ex_word) begin fails++; $display("FAIL warm_t7_hit: got hit=%b data=%h want 1 %h", ob_re_hit, ob_re_inst, ex_word); end
    tests_run++; if (sched_errs(ex_a) != 0) begin fails++; $display("FAIL warm_t7_no_read: got %0d reads want 4", rd_rel.size()); end
  endtask

  task automatic test_conflict();
    do_miss(32'h0000_0304, -1, -1, 0, 1'b1, -1, 32'd0);
    tests_run++; if (ob_hit0 !== 1'b0) begin fails++; $display("FAIL conflict_miss: got %b want 0", ob_hit0); end
    tests_run++; if (ob_pulse_rel != 6 || ob_word !== ex_word) begin fails++; $display("FAIL conflict_refill: got T+%0d %h want T+6 %h", ob_pulse_rel, ob_word, ex_word); end
    do_miss(32'h0000_0104, -1, -1, 0, 1'b0, -1, 32'd0);
    tests_run++; if (ob_hit0 !== 1'b0) begin fails++; $display("FAIL conflict_evicted: got %b want 0", ob_hit0); end
    tests_run++; if (ob_word !== 32'h0010_0513) begin fails++; $display("FAIL conflict_rerefill: got %h want 00100513", ob_word); end
  endtask

  task automatic test_flush_read();
    do_miss(32'h0000_5008, 3, -1, 0, 1'b0, 4, 32'h0000_0104);
    tests_run++; if (ob_pulse_cnt != 0) begin fails++; $display("FAIL flush_read_pulse: got %0d want 0", ob_pulse_cnt); end
    tests_run++; if (sched_errs(32'h0000_5008) != 0) begin fails++; $display("FAIL flush_read_seq: got %0d reads want 2", rd_rel.size()); end
    tests_run++; if (ob_re_hit !== 1'b1) begin fails++; $display("FAIL flush_read_idle_t4: got hit=%b want 1", ob_re_hit); end
    tests_run++; if (ob_meminst_end !== mdl_meminst) begin fails++; $display("FAIL flush_read_meminst: got %h want %h", ob_meminst_end, mdl_meminst); end
    do_miss(32'h0000_5008, -1, -1, 0, 1'b0, -1, 32'd0);
    tests_run++; if (ob_hit0 !== 1'b0 || ob_pulse_rel != 6) begin fails++; $display("FAIL flush_read_invalid: got hit=%b pulse T+%0d want 0 T+6", ob_hit0, ob_pulse_rel); end
  endtask

  task automatic test_flush_done();
    do_miss(32'h0000_6010, 6, -1, 0, 1'b0, 8, 32'h0000_6010);
    tests_run++; if (ob_pulse_cnt != 0) begin fails++; $display("FAIL flush_done_pulse: got %0d want 0", ob_pulse_cnt); end
    tests_run++; if (ob_re_hit !== 1'b1 || ob_re_inst !== ex_word) begin fails++; $display("FAIL flush_done_written: got hit=%b data=%h want 1 %h", ob_re_hit, ob_re_inst, ex_word); end
    tests_run++; if (ob_meminst_end !== ex_word) begin fails++; $display("FAIL flush_done_meminst: got %h want %h", ob_meminst_end, ex_word); end
  endtask

  task automatic test_flush_idle();
    rdy = 1'b1;
    bus.flush = 1'b1;
    bus.instEn = 1'b1;
    bus.instAddr = 32'h0000_9000;
    @(negedge clk);
    tests_run++; if (bus.hit !== 1'b0) begin fails++; $display("FAIL flush_idle_hit: got %b want 0", bus.hit); end
    next_cycle();
    bus.flush = 1'b0;
    bus.instEn = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.ram_rd !== 1'b0) begin fails++; $display("FAIL flush_idle_no_miss: got %b want 0", bus.ram_rd); end
    next_cycle();
    rdy = 1'b0;
    bus.instEn = 1'b1;
    bus.instAddr = 32'h0000_0104;
    @(negedge clk);
    tests_run++; if (bus.hit !== 1'b0 || bus.ram_rd !== 1'b0) begin fails++; $display("FAIL stall_idle_quiet: got hit=%b rd=%b want 0 0", bus.hit, bus.ram_rd); end
    next_cycle();
    rdy = 1'b1;
    bus.instEn = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.ram_rd !== 1'b0) begin fails++; $display("FAIL stall_idle_no_miss: got %b want 0", bus.ram_rd); end
    next_cycle();
  endtask

  task automatic test_stall();
    do_miss(32'h0000_7020, -1, 2, 3, 1'b1, -1, 32'd0);
    tests_run++; if (sched_errs(32'h0000_7020) != 0) begin fails++; $display("FAIL stall_seq: got %0d reads, last at T+%0d want 4 ending T+7", rd_rel.size(), (rd_rel.size() > 0) ? rd_rel[rd_rel.size()-1] : -1); end
    tests_run++; if (ob_pulse_rel != 9 || ob_pulse_cnt != 1) begin fails++; $display("FAIL stall_delay: got T+%0d x%0d want T+9 x1", ob_pulse_rel, ob_pulse_cnt); end
    tests_run++; if (ob_word !== ex_word) begin fails++; $display("FAIL stall_word: got %h want %h", ob_word, ex_word); end
  endtask

  task automatic test_inst_drop();
    do_miss(32'h0000_8044, -1, -1, 0, 1'b0, -1, 32'd0);
    tests_run++; if (ob_pulse_rel != 6 || ob_word !== ex_word) begin fails++; $display("FAIL drop_complete: got T+%0d %h want T+6 %h", ob_pulse_rel, ob_word, ex_word); end
  endtask

  task automatic test_random();
    logic [22:0] tg;
    logic [6:0]  ix;
    logic [31:0] addr;
    bit          stall;
    int          mode;
    int          f_at;
    int          s_at;
    int          s_len;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0:       tg = 23'h0;
        1:       tg = 23'h1;
        default: tg = 23'h2A5A5;
      endcase
      case ($urandom_range(0, 3))
        0:       ix = 7'h41;
        1:       ix = 7'h10;
        2:       ix = 7'h7F;
        default: ix = 7'h00;
      endcase
      addr = {tg, ix, 2'($urandom)};
      if (mdl_hit(addr)) begin
        stall = ($urandom_range(0, 3) == 0);
        rdy = !stall;
        bus.flush = 1'($urandom_range(0, 1));
        bus.instEn = 1'b1;
        bus.instAddr = addr;
        @(negedge clk);
        tests_run++; if (bus.hit !== !stall) begin fails++; $display("FAIL rnd_hit %h: got %b want %b", addr, bus.hit, !stall); end
        if (!stall) begin
          tests_run++; if (bus.cacheInst !== mdl_word[int'(ix)]) begin fails++; $display("FAIL rnd_hit_data %h: got %h want %h", addr, bus.cacheInst, mdl_word[int'(ix)]); end
        end
        tests_run++; if (bus.ram_rd !== 1'b0 || bus.memInstOutEn !== 1'b0) begin fails++; $display("FAIL rnd_hit_quiet %h: got rd=%b outen=%b want 0 0", addr, bus.ram_rd, bus.memInstOutEn); end
        next_cycle();
        rdy = 1'b1;
        bus.flush = 1'b0;
        bus.instEn = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.ram_rd !== 1'b0) begin fails++; $display("FAIL rnd_hit_no_miss %h: got %b want 0", addr, bus.ram_rd); end
        next_cycle();
      end else begin
        mode = $urandom_range(0, 4);
        f_at = -1;
        s_at = -1;
        s_len = 0;
        if (mode == 1) f_at = $urandom_range(1, 5);
        if (mode == 2) f_at = 6;
        if (mode == 3) begin
          s_at = $urandom_range(1, 6);
          s_len = $urandom_range(1, 3);
        end
        do_miss(addr, f_at, s_at, s_len, (mode == 4), -1, 32'd0);
        tests_run++; if (ob_hit0 !== 1'b0) begin fails++; $display("FAIL rnd_miss_hit %h: got %b want 0", addr, ob_hit0); end
        tests_run++; if (sched_errs(ex_a) != 0) begin fails++; $display("FAIL rnd_seq %h m%0d: got %0d reads want %0d", addr, mode, rd_rel.size(), ex_rd_rel.size()); end
        tests_run++; if (ob_pulse_rel != ex_pulse_rel || ob_pulse_cnt != ((ex_pulse_rel >= 0) ? 1 : 0)) begin fails++; $display("FAIL rnd_pulse %h m%0d: got T+%0d x%0d want T+%0d", addr, mode, ob_pulse_rel, ob_pulse_cnt, ex_pulse_rel); end
        if (ex_pulse_rel >= 0) begin
          tests_run++; if (ob_word !== ex_word) begin fails++; $display("FAIL rnd_word %h: got %h want %h", addr, ob_word, ex_word); end
        end
        tests_run++; if (ob_meminst_end !== mdl_meminst) begin fails++; $display("FAIL rnd_meminst %h: got %h want %h", addr, ob_meminst_end, mdl_meminst); end
        tests_run++; if (ob_both !== 1'b0) begin fails++; $display("FAIL rnd_hit_and_outen %h: got both high want never", addr); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.flush = 1'b0;
    bus.instEn = 1'b0;
    bus.instAddr = 32'd0;
    ram_over[32'h0000_0104] = 8'h13;
    ram_over[32'h0000_0105] = 8'h05;
    ram_over[32'h0000_0106] = 8'h10;
    ram_over[32'h0000_0107] = 8'h00;
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_flush_read();
    test_flush_done();
    test_flush_idle();
    test_stall();
    test_inst_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
